// File: rtl/param_bus_mux_if.sv
// Bus-side signals of param_bus_mux: source data/enables in, registered bus and conflict status out.
// bus_par exists only when BUS_PARITY_EN is defined.
interface param_bus_mux_if #(
  parameter int W     = 32,
  parameter int N_SRC = 24,
  parameter int CNT_W = 8
);
  localparam int SEL_W = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC*W-1:0] src_data;
  logic [N_SRC-1:0]   src_out;
  logic               conflict_clr;
  logic [W-1:0]       bus_out;
  logic               bus_valid;
  logic [SEL_W-1:0]   bus_src;
  logic               conflict;
  logic [CNT_W-1:0]   conflict_cnt;

`ifdef BUS_PARITY_EN
  logic bus_par;

  modport master (
    output src_data, src_out, conflict_clr,
    input  bus_out, bus_valid, bus_src, conflict, conflict_cnt, bus_par
  );

  modport slave (
    input  src_data, src_out, conflict_clr,
    output bus_out, bus_valid, bus_src, conflict, conflict_cnt, bus_par
  );
`else
  modport master (
    output src_data, src_out, conflict_clr,
    input  bus_out, bus_valid, bus_src, conflict, conflict_cnt
  );

  modport slave (
    input  src_data, src_out, conflict_clr,
    output bus_out, bus_valid, bus_src, conflict, conflict_cnt
  );
`endif
endinterface

// File: rtl/param_bus_mux.sv
// Registered N-source bus multiplexer, highest-index enable wins, with multi-driver conflict tracking.
// Optional macro BUS_PARITY_EN adds a registered even-parity bit for bus_out.
module param_bus_mux #(
  parameter int W         = 32,
  parameter int N_SRC     = 24,
  parameter bit HOLD_LAST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic          clock,
  input  logic          clear,
  param_bus_mux_if.slave bus
);
  localparam int SEL_W = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1;

  logic [W-1:0]     winData;
  logic [SEL_W-1:0] winIdx;
  logic             anyDrive;
  logic             multiDrive;

  logic [W-1:0]     busOutQ,   busOutNext;
  logic             busValidQ, busValidNext;
  logic [SEL_W-1:0] busSrcQ,   busSrcNext;
  logic             conflictQ, conflictNext;
  logic [CNT_W-1:0] cntQ,      cntNext;

  // Ascending scan: the last active enable seen is the highest index.
  always_comb begin
    winData = '0;
    winIdx  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.src_out[i]) begin
        winData = bus.src_data[i*W +: W];
        winIdx  = SEL_W'(i);
      end
    end
  end

  assign anyDrive   = |bus.src_out;
  assign multiDrive = |(bus.src_out & (bus.src_out - N_SRC'(1)));

  always_comb begin
    busOutNext   = busOutQ;
    busValidNext = 1'b0;
    busSrcNext   = busSrcQ;
    if (anyDrive) begin
      busOutNext   = winData;
      busValidNext = 1'b1;
      busSrcNext   = winIdx;
    end else if (!HOLD_LAST) begin
      busOutNext = '0;
    end
  end

  // A conflict in the same cycle as a clear restarts the count at one.
  always_comb begin
    conflictNext = conflictQ;
    cntNext      = cntQ;
    if (multiDrive) begin
      conflictNext = 1'b1;
      if (bus.conflict_clr)
        cntNext = CNT_W'(1);
      else if (cntQ != '1)
        cntNext = cntQ + CNT_W'(1);
    end else if (bus.conflict_clr) begin
      conflictNext = 1'b0;
      cntNext      = '0;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      busOutQ   <= '0;
      busValidQ <= 1'b0;
      busSrcQ   <= '0;
      conflictQ <= 1'b0;
      cntQ      <= '0;
    end else begin
      busOutQ   <= busOutNext;
      busValidQ <= busValidNext;
      busSrcQ   <= busSrcNext;
      conflictQ <= conflictNext;
      cntQ      <= cntNext;
    end
  end

  assign bus.bus_out      = busOutQ;
  assign bus.bus_valid    = busValidQ;
  assign bus.bus_src      = busSrcQ;
  assign bus.conflict     = conflictQ;
  assign bus.conflict_cnt = cntQ;

`ifdef BUS_PARITY_EN
  logic parQ;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      parQ <= 1'b0;
    else
      parQ <= ^busOutNext;
  end

  assign bus.bus_par = parQ;
`endif
endmodule

// File: tb/tb_param_bus_mux.sv
// Bench for param_bus_mux: three instances (hold-last, zero-idle, 2-bit counter) against a behavioural model.
module tb_param_bus_mux;
  localparam int W     = 32;
  localparam int N_SRC = 24;

  logic               clock = 1'b0;
  logic               clear;
  logic [N_SRC*W-1:0] srcFlat;
  logic [N_SRC-1:0]   srcOut;
  logic               conflictClr;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  param_bus_mux_if #(.W(W), .N_SRC(N_SRC), .CNT_W(8)) ifA ();
  param_bus_mux_if #(.W(W), .N_SRC(N_SRC), .CNT_W(8)) ifB ();
  param_bus_mux_if #(.W(W), .N_SRC(N_SRC), .CNT_W(2)) ifC ();

  assign ifA.src_data = srcFlat;  assign ifA.src_out = srcOut;  assign ifA.conflict_clr = conflictClr;
  assign ifB.src_data = srcFlat;  assign ifB.src_out = srcOut;  assign ifB.conflict_clr = conflictClr;
  assign ifC.src_data = srcFlat;  assign ifC.src_out = srcOut;  assign ifC.conflict_clr = conflictClr;

  param_bus_mux #(.W(W), .N_SRC(N_SRC), .HOLD_LAST(1'b1), .CNT_W(8)) dutA (.clock(clock), .clear(clear), .bus(ifA));
  param_bus_mux #(.W(W), .N_SRC(N_SRC), .HOLD_LAST(1'b0), .CNT_W(8)) dutB (.clock(clock), .clear(clear), .bus(ifB));
  param_bus_mux #(.W(W), .N_SRC(N_SRC), .HOLD_LAST(1'b1), .CNT_W(2)) dutC (.clock(clock), .clear(clear), .bus(ifC));

  typedef struct {
    longint busOut;
    longint valid;
    longint src;
    longint conflict;
    longint cnt;
    longint par;
  } mdl_t;

  mdl_t mA, mB, mC;

  function automatic mdl_t modelReset();
    mdl_t m;
    m.busOut = 0; m.valid = 0; m.src = 0; m.conflict = 0; m.cnt = 0; m.par = 0;
    return m;
  endfunction

  function automatic mdl_t modelStep(mdl_t mIn, bit holdLast, longint cntMax,
                                     logic [N_SRC-1:0] so, logic [N_SRC*W-1:0] sd, logic clr);
    mdl_t m = mIn;
    int   drivers = $countones(so);
    longint v = longint'(so);
    int   top;
    logic [W-1:0] word;
    if (drivers > 0) begin
      top      = $clog2(v + 1) - 1;
      word     = sd[top*W +: W];
      m.busOut = longint'(word);
      m.par    = longint'(^word);
      m.valid  = 1;
      m.src    = top;
    end else begin
      m.valid = 0;
      if (!holdLast) begin
        m.busOut = 0;
        m.par    = 0;
      end
    end
    if (drivers >= 2) begin
      m.conflict = 1;
      if (clr) m.cnt = 1;
      else if (m.cnt < cntMax) m.cnt = m.cnt + 1;
    end else if (clr) begin
      m.conflict = 0;
      m.cnt      = 0;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    chk("A.bus_out",  longint'(ifA.bus_out),      mA.busOut);
    chk("A.valid",    longint'(ifA.bus_valid),    mA.valid);
    chk("A.src",      longint'(ifA.bus_src),      mA.src);
    chk("A.conflict", longint'(ifA.conflict),     mA.conflict);
    chk("A.cnt",      longint'(ifA.conflict_cnt), mA.cnt);
    chk("B.bus_out",  longint'(ifB.bus_out),      mB.busOut);
    chk("B.valid",    longint'(ifB.bus_valid),    mB.valid);
    chk("B.src",      longint'(ifB.bus_src),      mB.src);
    chk("C.cnt",      longint'(ifC.conflict_cnt), mC.cnt);
    chk("C.conflict", longint'(ifC.conflict),     mC.conflict);
`ifdef BUS_PARITY_EN
    chk("A.par", longint'(ifA.bus_par), mA.par);
    chk("B.par", longint'(ifB.bus_par), mB.par);
`endif
  endtask

  task automatic setSrc(input int idx, input logic [W-1:0] val);
    srcFlat[idx*W +: W] = val;
  endtask

  task automatic randomizeData();
    for (int i = 0; i < N_SRC; i++) srcFlat[i*W +: W] = $urandom;
  endtask

  task automatic drive(input logic [N_SRC-1:0] so, input logic clr);
    srcOut      = so;
    conflictClr = clr;
    @(posedge clock);
    mA = modelStep(mA, 1'b1, 255, so, srcFlat, clr);
    mB = modelStep(mB, 1'b0, 255, so, srcFlat, clr);
    mC = modelStep(mC, 1'b1, 3,   so, srcFlat, clr);
    #1;
    checkAll();
  endtask

  logic [N_SRC-1:0] twoHot;
  longint satSeq [5] = '{1, 2, 3, 3, 3};

  initial begin
    clear       = 1'b1;
    srcOut      = '0;
    conflictClr = 1'b0;
    srcFlat     = '0;
    mA = modelReset(); mB = modelReset(); mC = modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    checkAll();

    // Asynchronous reset mid-cycle while a source is driving.
    randomizeData();
    repeat (3) drive(N_SRC'(1) << 3, 1'b0);
    #3 clear = 1'b1;
    #1;
    mA = modelReset(); mB = modelReset(); mC = modelReset();
    chk("rst.bus_out",  longint'(ifA.bus_out),      0);
    chk("rst.valid",    longint'(ifA.bus_valid),    0);
    chk("rst.src",      longint'(ifA.bus_src),      0);
    chk("rst.conflict", longint'(ifA.conflict),     0);
    chk("rst.cnt",      longint'(ifA.conflict_cnt), 0);
    @(negedge clock);
    clear = 1'b0;

    // Single driver, then idle.
    setSrc(5, 32'hDEADBEEF);
    drive(N_SRC'(1) << 5, 1'b0);
    chk("single.bus_out",  longint'(ifA.bus_out),   longint'(32'hDEADBEEF));
    chk("single.src",      longint'(ifA.bus_src),   5);
    chk("single.valid",    longint'(ifA.bus_valid), 1);
    chk("single.conflict", longint'(ifA.conflict),  0);
    drive('0, 1'b0);
    chk("idle.hold.bus_out", longint'(ifA.bus_out),   longint'(32'hDEADBEEF));
    chk("idle.hold.valid",   longint'(ifA.bus_valid), 0);
    chk("idle.hold.src",     longint'(ifA.bus_src),   5);
    chk("idle.zero.bus_out", longint'(ifB.bus_out),   0);

    // Two drivers for three cycles.
    setSrc(2, 32'h11);
    setSrc(20, 32'h22);
    twoHot = (N_SRC'(1) << 2) | (N_SRC'(1) << 20);
    repeat (3) drive(twoHot, 1'b0);
    chk("conf.bus_out",  longint'(ifA.bus_out),      32'h22);
    chk("conf.src",      longint'(ifA.bus_src),      20);
    chk("conf.conflict", longint'(ifA.conflict),     1);
    chk("conf.cnt",      longint'(ifA.conflict_cnt), 3);
    drive('0, 1'b0);
    chk("conf.hold.conflict", longint'(ifA.conflict),     1);
    chk("conf.hold.cnt",      longint'(ifA.conflict_cnt), 3);

    // Clear alone, then clear colliding with a new conflict.
    drive('0, 1'b1);
    chk("clr.conflict", longint'(ifA.conflict),     0);
    chk("clr.cnt",      longint'(ifA.conflict_cnt), 0);
    drive(twoHot, 1'b1);
    chk("clrev.conflict", longint'(ifA.conflict),     1);
    chk("clrev.cnt",      longint'(ifA.conflict_cnt), 1);

    // Saturation of the 2-bit counter.
    drive('0, 1'b1);
    for (int k = 0; k < 5; k++) drive(twoHot, 1'b0);
    drive('0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(twoHot, 1'b0);
      chk($sformatf("sat.cnt%0d", k), longint'(ifC.conflict_cnt), satSeq[k]);
    end

`ifdef BUS_PARITY_EN
    setSrc(5, 32'h00000007);
    drive(N_SRC'(1) << 5, 1'b0);
    chk("par.seven", longint'(ifA.bus_par), 1);
`endif

    // Random traffic: idle, one-hot, or sparse multi-driver patterns.
    for (int n = 0; n < 400; n++) begin
      logic [N_SRC-1:0] so;
      int mode;
      randomizeData();
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: so = '0;
        1: so = N_SRC'(1) << $urandom_range(0, N_SRC - 1);
        2: so = (N_SRC'(1) << $urandom_range(0, N_SRC - 1)) | (N_SRC'(1) << $urandom_range(0, N_SRC - 1));
        default: so = N_SRC'($urandom) & N_SRC'($urandom);
      endcase
      drive(so, ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/param_bus_mux.md
Name: param_bus_mux

Overview:
- Registered, parametrised successor to the datapath's single-bus source multiplexer.
- Selects one of N_SRC W-bit sources onto the shared bus using the per-source out-enables from control logic.
- The bus is registered with one cycle of latency. It records the index of the driving source.
- It detects multi-driver conflicts, keeps a sticky conflict flag and a saturating conflict count, and offers a selectable idle behaviour.
- Sits between the register file/special registers and every bus load point.

Parameters:
- W, 32, bus and source data width in bits.
- N_SRC, 24, number of bus sources. Minimum 2.
- HOLD_LAST, 1, idle-cycle behaviour: 1 = bus holds its last value; 0 = bus drives all zeros.
- CNT_W, 8, width of the conflict counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- src_data  in  N_SRC*W  flattened source data; source i occupies bits [i*W+W-1 : i*W].
- src_out  in  N_SRC  per-source out-enables. One-hot is expected; any pattern is legal.
- conflict_clr  in  1  synchronous clear of the conflict flag and the conflict counter.
- bus_out  out  W  registered bus value.
- bus_valid  out  1  registered; 1 when some source drove bus_out this cycle.
- bus_src  out  SEL_W  registered index of the winning source. SEL_W = max(1, clog2(N_SRC)).
- conflict  out  1  sticky; set when 2 or more enables were active in any cycle.
- conflict_cnt  out  CNT_W  count of conflict cycles; saturates and does not wrap.

Behaviour:
- Reset (clear=1, asynchronous):
  - bus_out=0, bus_valid=0, bus_src=0, conflict=0, conflict_cnt=0.
  - Reset has immediate effect. It overrides every other input, including in the middle of a conflict burst.
- Selection (combinational, ahead of the register):
  - Priority is highest index wins. Among all active src_out bits, the one with the largest index i is selected.
  - With conventional ordering (R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, Y) this preserves the existing last-enable-wins ordering.
- Latency: src_out and src_data sampled at edge k appear on bus_out/bus_valid/bus_src after edge k.
- Active cycle (src_out != 0): bus_out <= data of the selected source; bus_src <= its index; bus_valid <= 1.
- Idle cycle (src_out == 0): bus_valid <= 0 and bus_src holds its previous value.
  - HOLD_LAST=1: bus_out holds its previous value.
  - HOLD_LAST=0: bus_out <= 0.
- Conflict detection: a conflict cycle is any cycle where popcount(src_out) >= 2.
  - The bus still takes the priority winner's data; there is no corruption or masking.
- Conflict flag and counter, evaluated in priority order:
  1. Conflict cycle with conflict_clr=1: conflict <= 1 and conflict_cnt <= 1. A new event beats the clear.
  2. Conflict cycle with conflict_clr=0: conflict <= 1. conflict_cnt increments unless it already equals 2^CNT_W-1, where it holds.
  3. No conflict with conflict_clr=1: conflict <= 0 and conflict_cnt <= 0.
  4. Otherwise: both hold.
- No internal state other than the output registers, the flag and the counter. There is no FSM beyond the flag/counter update rule above.
- Source indices at or above N_SRC do not exist. The flattened port is sized exactly N_SRC*W.

Optional Feature:
- Macro: BUS_PARITY_EN.
- Defined:
  - Adds output bus_par (1 bit, registered alongside bus_out) = even parity (XOR-reduce) of the value loaded into bus_out.
  - Reset value is 0.
  - On an idle hold it holds with bus_out. With HOLD_LAST=0 on an idle cycle it becomes 0.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset: assert clear mid-cycle with src_out=1<<3 -> all outputs 0 immediately, before any clock edge.
2. Single driver: src_out=1<<5, source5=0xDEADBEEF -> after one edge bus_out=0xDEADBEEF, bus_src=5, bus_valid=1, conflict=0.
3. Idle, HOLD_LAST=1 then 0: after test 2 set src_out=0 -> HOLD_LAST=1: bus_out stays 0xDEADBEEF, bus_valid=0, bus_src=5. HOLD_LAST=0: bus_out=0.
4. Conflict: src_out=(1<<2)|(1<<20), source2=0x11, source20=0x22 for 3 cycles -> bus_out=0x22, bus_src=20, conflict=1, conflict_cnt=3. Then src_out=0 -> flag and count hold.
5. Clear versus event: from conflict_cnt=3, assert conflict_clr with no conflict -> 0/0. Then conflict_clr together with a conflict -> conflict=1, conflict_cnt=1.
6. Saturation with CNT_W=2: 5 consecutive conflict cycles -> conflict_cnt sequence 1,2,3,3,3. With BUS_PARITY_EN, driving 0x00000007 -> bus_par=1.
